// File: rtl/epu_buff_rotator.sv
// Buffer-role rotator: maps EPU-in/EPU-out/DMA clients onto NUM_BUF SRAMs
// and advances the mapping with a drained request/ack swap handshake.
module epu_buff_rotator #(
  parameter int NUM_BUF = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int WEB_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         epu_in_cs_i,
  input  logic                         epu_in_oe_i,
  input  logic [ADDR_W-1:0]            epu_in_addr_i,
  input  logic [WEB_W-1:0]             epu_in_W_req_i,
  input  logic [DATA_W-1:0]            epu_in_W_data_i,
  output logic [DATA_W-1:0]            epu_in_R_data_o,
  input  logic                         epu_out_cs_i,
  input  logic                         epu_out_oe_i,
  input  logic [ADDR_W-1:0]            epu_out_addr_i,
  input  logic [WEB_W-1:0]             epu_out_W_req_i,
  input  logic [DATA_W-1:0]            epu_out_W_data_i,
  output logic [DATA_W-1:0]            epu_out_R_data_o,
  input  logic                         dma_cs_i,
  input  logic                         dma_oe_i,
  input  logic [ADDR_W-1:0]            dma_addr_i,
  input  logic [WEB_W-1:0]             dma_W_req_i,
  input  logic [DATA_W-1:0]            dma_W_data_i,
  output logic [DATA_W-1:0]            dma_R_data_o,
  output logic [NUM_BUF-1:0]           buf_cs_o,
  output logic [NUM_BUF-1:0]           buf_oe_o,
  output logic [NUM_BUF*ADDR_W-1:0]    buf_addr_o,
  output logic [NUM_BUF*WEB_W-1:0]     buf_W_req_o,
  output logic [NUM_BUF*DATA_W-1:0]    buf_W_data_o,
  input  logic [NUM_BUF*DATA_W-1:0]    buf_R_data_i,
  input  logic                         swap_req_i,
  output logic                         swap_ack_o,
  output logic                         stall_o,
  input  logic                         base_load_i,
  input  logic [$clog2(NUM_BUF)-1:0]   base_val_i,
  output logic [$clog2(NUM_BUF)-1:0]   base_o,
  output logic [15:0]                  swap_cnt_o
);

  localparam int BW = $clog2(NUM_BUF);
  localparam bit HAS_DMA = (NUM_BUF >= 3);

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   base_q;
  logic [15:0]     cnt_q;
  logic [BW-1:0]   in_idx, out_idx, dma_idx;
  logic            gate;

  logic            in_vld_q, out_vld_q, dma_vld_q;
  logic [BW-1:0]   in_sel_q, out_sel_q, dma_sel_q;
  logic [DATA_W-1:0] rdat [NUM_BUF];

  // (x + k) mod NUM_BUF for x < NUM_BUF or a raw base_val_i, k <= 2
  function automatic logic [BW-1:0] wrap_add(
    input logic [BW-1:0] x,
    input logic [1:0]    k
  );
    logic [BW:0] s;
    s = (BW+1)'(x) + (BW+1)'(k);
    if (s >= (BW+1)'(NUM_BUF)) s = s - (BW+1)'(NUM_BUF);
    return s[BW-1:0];
  endfunction

  assign stall_o    = (state_q != RUN);
  assign gate       = stall_o | rst;
  assign base_o     = base_q;
  assign swap_cnt_o = cnt_q;

  assign in_idx  = base_q;
  assign out_idx = wrap_add(base_q, 2'd1);
  assign dma_idx = wrap_add(base_q, 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    swap_ack_o = 1'b0;
    unique case (state_q)
      RUN:   if (swap_req_i && !base_load_i) state_d = DRAIN;
      DRAIN: state_d = SWAP;
      SWAP: begin
        state_d    = RUN;
        swap_ack_o = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == SWAP) begin
      base_q <= wrap_add(base_q, 2'd1);
      cnt_q  <= cnt_q + 16'd1;
    end else if (state_q == RUN && base_load_i) begin
      base_q <= wrap_add(base_val_i, 2'd0);
    end
  end

  always_comb begin
    buf_cs_o     = '0;
    buf_oe_o     = '0;
    buf_addr_o   = '0;
    buf_W_req_o  = '0;
    buf_W_data_o = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (BW'(i) == in_idx) begin
        buf_cs_o[i] = epu_in_cs_i;
        buf_oe_o[i] = epu_in_oe_i;
        buf_addr_o[i*ADDR_W +: ADDR_W]   = epu_in_addr_i;
        buf_W_req_o[i*WEB_W +: WEB_W]    = epu_in_W_req_i;
        buf_W_data_o[i*DATA_W +: DATA_W] = epu_in_W_data_i;
      end else if (BW'(i) == out_idx) begin
        buf_cs_o[i] = epu_out_cs_i;
        buf_oe_o[i] = epu_out_oe_i;
        buf_addr_o[i*ADDR_W +: ADDR_W]   = epu_out_addr_i;
        buf_W_req_o[i*WEB_W +: WEB_W]    = epu_out_W_req_i;
        buf_W_data_o[i*DATA_W +: DATA_W] = epu_out_W_data_i;
      end else if (HAS_DMA && BW'(i) == dma_idx) begin
        buf_cs_o[i] = dma_cs_i;
        buf_oe_o[i] = dma_oe_i;
        buf_addr_o[i*ADDR_W +: ADDR_W]   = dma_addr_i;
        buf_W_req_o[i*WEB_W +: WEB_W]    = dma_W_req_i;
        buf_W_data_o[i*DATA_W +: DATA_W] = dma_W_data_i;
      end
    end
    if (gate) begin
      buf_cs_o    = '0;
      buf_oe_o    = '0;
      buf_W_req_o = '0;
    end
  end

  for (genvar g = 0; g < NUM_BUF; g++) begin : g_rdat
    assign rdat[g] = buf_R_data_i[g*DATA_W +: DATA_W];
  end

  // Select is captured at issue so returns survive a remap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      dma_vld_q <= 1'b0;
      in_sel_q  <= '0;
      out_sel_q <= '0;
      dma_sel_q <= '0;
    end else begin
      in_vld_q  <= epu_in_cs_i & epu_in_oe_i & ~stall_o;
      out_vld_q <= epu_out_cs_i & epu_out_oe_i & ~stall_o;
      dma_vld_q <= HAS_DMA & dma_cs_i & dma_oe_i & ~stall_o;
      in_sel_q  <= in_idx;
      out_sel_q <= out_idx;
      dma_sel_q <= dma_idx;
    end
  end

  assign epu_in_R_data_o  = in_vld_q  ? rdat[in_sel_q]  : '0;
  assign epu_out_R_data_o = out_vld_q ? rdat[out_sel_q] : '0;
  assign dma_R_data_o     = dma_vld_q ? rdat[dma_sel_q] : '0;

endmodule

// File: tb/tb_epu_buff_rotator.sv
// Directed bench for epu_buff_rotator: three instances (NUM_BUF 3, 2, 4)
// exercising mapping, read return, swap handshake and base loading.
module tb_epu_buff_rotator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- NUM_BUF = 3 ----------------
  logic        rst3;
  logic        ei_cs3, ei_oe3, eo_cs3, eo_oe3, d_cs3, d_oe3;
  logic [15:0] ei_addr3, eo_addr3, d_addr3;
  logic [3:0]  ei_wr3, eo_wr3, d_wr3;
  logic [31:0] ei_wd3, eo_wd3, d_wd3;
  logic [31:0] ei_rd3, eo_rd3, d_rd3;
  logic [2:0]  bcs3, boe3;
  logic [47:0] baddr3;
  logic [11:0] bwr3;
  logic [95:0] bwd3, brd3;
  logic        sreq3, sack3, stall3, bload3;
  logic [1:0]  bval3, base3;
  logic [15:0] cnt3;

  epu_buff_rotator #(.NUM_BUF(3)) dut3 (
    .clk(clk), .rst(rst3),
    .epu_in_cs_i(ei_cs3), .epu_in_oe_i(ei_oe3),
    .epu_in_addr_i(ei_addr3), .epu_in_W_req_i(ei_wr3),
    .epu_in_W_data_i(ei_wd3), .epu_in_R_data_o(ei_rd3),
    .epu_out_cs_i(eo_cs3), .epu_out_oe_i(eo_oe3),
    .epu_out_addr_i(eo_addr3), .epu_out_W_req_i(eo_wr3),
    .epu_out_W_data_i(eo_wd3), .epu_out_R_data_o(eo_rd3),
    .dma_cs_i(d_cs3), .dma_oe_i(d_oe3),
    .dma_addr_i(d_addr3), .dma_W_req_i(d_wr3),
    .dma_W_data_i(d_wd3), .dma_R_data_o(d_rd3),
    .buf_cs_o(bcs3), .buf_oe_o(boe3), .buf_addr_o(baddr3),
    .buf_W_req_o(bwr3), .buf_W_data_o(bwd3), .buf_R_data_i(brd3),
    .swap_req_i(sreq3), .swap_ack_o(sack3), .stall_o(stall3),
    .base_load_i(bload3), .base_val_i(bval3), .base_o(base3),
    .swap_cnt_o(cnt3)
  );

  // ---------------- NUM_BUF = 2 ----------------
  logic        rst2;
  logic        ei_cs2, ei_oe2, eo_cs2, eo_oe2, d_cs2, d_oe2;
  logic [15:0] ei_addr2, eo_addr2, d_addr2;
  logic [3:0]  ei_wr2, eo_wr2, d_wr2;
  logic [31:0] ei_wd2, eo_wd2, d_wd2;
  logic [31:0] ei_rd2, eo_rd2, d_rd2;
  logic [1:0]  bcs2, boe2;
  logic [31:0] baddr2;
  logic [7:0]  bwr2;
  logic [63:0] bwd2, brd2;
  logic        sreq2, sack2, stall2, bload2;
  logic [0:0]  bval2, base2;
  logic [15:0] cnt2;

  epu_buff_rotator #(.NUM_BUF(2)) dut2 (
    .clk(clk), .rst(rst2),
    .epu_in_cs_i(ei_cs2), .epu_in_oe_i(ei_oe2),
    .epu_in_addr_i(ei_addr2), .epu_in_W_req_i(ei_wr2),
    .epu_in_W_data_i(ei_wd2), .epu_in_R_data_o(ei_rd2),
    .epu_out_cs_i(eo_cs2), .epu_out_oe_i(eo_oe2),
    .epu_out_addr_i(eo_addr2), .epu_out_W_req_i(eo_wr2),
    .epu_out_W_data_i(eo_wd2), .epu_out_R_data_o(eo_rd2),
    .dma_cs_i(d_cs2), .dma_oe_i(d_oe2),
    .dma_addr_i(d_addr2), .dma_W_req_i(d_wr2),
    .dma_W_data_i(d_wd2), .dma_R_data_o(d_rd2),
    .buf_cs_o(bcs2), .buf_oe_o(boe2), .buf_addr_o(baddr2),
    .buf_W_req_o(bwr2), .buf_W_data_o(bwd2), .buf_R_data_i(brd2),
    .swap_req_i(sreq2), .swap_ack_o(sack2), .stall_o(stall2),
    .base_load_i(bload2), .base_val_i(bval2), .base_o(base2),
    .swap_cnt_o(cnt2)
  );

  // ---------------- NUM_BUF = 4 ----------------
  logic        rst4;
  logic        ei_cs4, ei_oe4, eo_cs4, eo_oe4, d_cs4, d_oe4;
  logic [15:0] ei_addr4, eo_addr4, d_addr4;
  logic [3:0]  ei_wr4, eo_wr4, d_wr4;
  logic [31:0] ei_wd4, eo_wd4, d_wd4;
  logic [31:0] ei_rd4, eo_rd4, d_rd4;
  logic [3:0]  bcs4, boe4;
  logic [63:0] baddr4;
  logic [15:0] bwr4;
  logic [127:0] bwd4, brd4;
  logic        sreq4, sack4, stall4, bload4;
  logic [1:0]  bval4, base4;
  logic [15:0] cnt4;

  epu_buff_rotator #(.NUM_BUF(4)) dut4 (
    .clk(clk), .rst(rst4),
    .epu_in_cs_i(ei_cs4), .epu_in_oe_i(ei_oe4),
    .epu_in_addr_i(ei_addr4), .epu_in_W_req_i(ei_wr4),
    .epu_in_W_data_i(ei_wd4), .epu_in_R_data_o(ei_rd4),
    .epu_out_cs_i(eo_cs4), .epu_out_oe_i(eo_oe4),
    .epu_out_addr_i(eo_addr4), .epu_out_W_req_i(eo_wr4),
    .epu_out_W_data_i(eo_wd4), .epu_out_R_data_o(eo_rd4),
    .dma_cs_i(d_cs4), .dma_oe_i(d_oe4),
    .dma_addr_i(d_addr4), .dma_W_req_i(d_wr4),
    .dma_W_data_i(d_wd4), .dma_R_data_o(d_rd4),
    .buf_cs_o(bcs4), .buf_oe_o(boe4), .buf_addr_o(baddr4),
    .buf_W_req_o(bwr4), .buf_W_data_o(bwd4), .buf_R_data_i(brd4),
    .swap_req_i(sreq4), .swap_ack_o(sack4), .stall_o(stall4),
    .base_load_i(bload4), .base_val_i(bval4), .base_o(base4),
    .swap_cnt_o(cnt4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr3();
    {ei_cs3, ei_oe3, eo_cs3, eo_oe3, d_cs3, d_oe3} = '0;
    {ei_addr3, eo_addr3, d_addr3} = '0;
    {ei_wr3, eo_wr3, d_wr3} = '0;
    {ei_wd3, eo_wd3, d_wd3} = '0;
  endtask

  task automatic clr2();
    {ei_cs2, ei_oe2, eo_cs2, eo_oe2, d_cs2, d_oe2} = '0;
    {ei_addr2, eo_addr2, d_addr2} = '0;
    {ei_wr2, eo_wr2, d_wr2} = '0;
    {ei_wd2, eo_wd2, d_wd2} = '0;
  endtask

  task automatic clr4();
    {ei_cs4, ei_oe4, eo_cs4, eo_oe4, d_cs4, d_oe4} = '0;
    {ei_addr4, eo_addr4, d_addr4} = '0;
    {ei_wr4, eo_wr4, d_wr4} = '0;
    {ei_wd4, eo_wd4, d_wd4} = '0;
  endtask

  task automatic test_reset();
    ei_cs3 = 1'b1;
    ei_oe3 = 1'b1;
    #2;
    checks++;
    if (bcs3 !== 3'b000) begin
      failures++;
      $display("FAIL rst_cs got=%0h exp=0", bcs3);
    end
    checks++;
    if (base3 !== 2'd0 || cnt3 !== 16'd0) begin
      failures++;
      $display("FAIL rst_base_cnt got=%0h/%0h exp=0/0", base3, cnt3);
    end
    checks++;
    if (stall3 !== 1'b0 || sack3 !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall_ack got=%0b/%0b exp=0/0", stall3, sack3);
    end
    step();
    checks++;
    if (ei_rd3 !== 32'h0) begin
      failures++;
      $display("FAIL rst_rdata got=%0h exp=0", ei_rd3);
    end
    clr3();
    rst3 = 1'b0;
    rst2 = 1'b0;
    rst4 = 1'b0;
    step();
  endtask

  task automatic test_mapping();
    brd3 = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    ei_cs3 = 1'b1; ei_oe3 = 1'b1; ei_addr3 = 16'h0010;
    #1;
    checks++;
    if (bcs3 !== 3'b001 || boe3 !== 3'b001) begin
      failures++;
      $display("FAIL map_in_cs got=%0h/%0h exp=1/1", bcs3, boe3);
    end
    checks++;
    if (baddr3[15:0] !== 16'h0010) begin
      failures++;
      $display("FAIL map_in_addr got=%0h exp=10", baddr3[15:0]);
    end
    step();
    clr3();
    eo_cs3 = 1'b1; eo_oe3 = 1'b1; eo_addr3 = 16'h0020;
    checks++;
    if (ei_rd3 !== 32'hAAAA0000) begin
      failures++;
      $display("FAIL map_in_rdata got=%0h exp=aaaa0000", ei_rd3);
    end
    #1;
    checks++;
    if (bcs3 !== 3'b010 || baddr3[31:16] !== 16'h0020) begin
      failures++;
      $display("FAIL map_out got=%0h/%0h exp=2/20", bcs3, baddr3[31:16]);
    end
    step();
    clr3();
    d_cs3 = 1'b1; d_oe3 = 1'b1; d_addr3 = 16'h0030;
    checks++;
    if (eo_rd3 !== 32'hBBBB0001) begin
      failures++;
      $display("FAIL map_out_rdata got=%0h exp=bbbb0001", eo_rd3);
    end
    #1;
    checks++;
    if (bcs3 !== 3'b100 || baddr3[47:32] !== 16'h0030) begin
      failures++;
      $display("FAIL map_dma got=%0h/%0h exp=4/30", bcs3, baddr3[47:32]);
    end
    step();
    clr3();
    checks++;
    if (d_rd3 !== 32'hCCCC0002) begin
      failures++;
      $display("FAIL map_dma_rdata got=%0h exp=cccc0002", d_rd3);
    end
    step();
    checks++;
    if (d_rd3 !== 32'h0) begin
      failures++;
      $display("FAIL idle_rdata got=%0h exp=0", d_rd3);
    end
  endtask

  task automatic test_write_path();
    eo_cs3 = 1'b1; eo_wr3 = 4'h5; eo_wd3 = 32'h12345678;
    #1;
    checks++;
    if (bwr3 !== 12'h050) begin
      failures++;
      $display("FAIL wr_req got=%0h exp=050", bwr3);
    end
    checks++;
    if (bwd3[63:32] !== 32'h12345678 || bwd3[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL wr_data got=%0h exp=12345678", bwd3[63:32]);
    end
    clr3();
    step();
  endtask

  task automatic test_three_swaps();
    logic [1:0] exp_base;
    for (int k = 0; k < 3; k++) begin
      exp_base = (k == 2) ? 2'd0 : 2'(k + 1);
      sreq3 = 1'b1;
      #1;
      checks++;
      if (stall3 !== 1'b0) begin
        failures++;
        $display("FAIL sw%0d_t0_stall got=%0b exp=0", k, stall3);
      end
      step();
      checks++;
      if (stall3 !== 1'b1 || sack3 !== 1'b0) begin
        failures++;
        $display("FAIL sw%0d_drain got=%0b/%0b exp=1/0", k, stall3, sack3);
      end
      step();
      checks++;
      if (stall3 !== 1'b1 || sack3 !== 1'b1) begin
        failures++;
        $display("FAIL sw%0d_swap got=%0b/%0b exp=1/1", k, stall3, sack3);
      end
      sreq3 = 1'b0;
      step();
      checks++;
      if (stall3 !== 1'b0 || sack3 !== 1'b0 || base3 !== exp_base) begin
        failures++;
        $display("FAIL sw%0d_done got=%0b/%0b/%0d exp=0/0/%0d",
                 k, stall3, sack3, base3, exp_base);
      end
      if (k == 0) begin
        ei_cs3 = 1'b1; ei_oe3 = 1'b1;
        #1;
        checks++;
        if (bcs3 !== 3'b010) begin
          failures++;
          $display("FAIL sw_in_remap got=%0h exp=2", bcs3);
        end
        clr3();
      end
    end
    checks++;
    if (cnt3 !== 16'd3) begin
      failures++;
      $display("FAIL sw_count got=%0d exp=3", cnt3);
    end
  endtask

  task automatic test_read_across_swap();
    brd3[63:32] = 32'hDEADBEEF;
    eo_cs3 = 1'b1; eo_oe3 = 1'b1;
    sreq3 = 1'b1;
    step();
    checks++;
    if (eo_rd3 !== 32'hDEADBEEF || stall3 !== 1'b1) begin
      failures++;
      $display("FAIL xs_rdata got=%0h/%0b exp=deadbeef/1", eo_rd3, stall3);
    end
    ei_cs3 = 1'b1; ei_wr3 = 4'hF;
    bload3 = 1'b1; bval3 = 2'd2;
    #1;
    checks++;
    if (bcs3 !== 3'b0 || boe3 !== 3'b0 || bwr3 !== 12'h0) begin
      failures++;
      $display("FAIL xs_gate got=%0h/%0h/%0h exp=0/0/0", bcs3, boe3, bwr3);
    end
    step();
    checks++;
    if (sack3 !== 1'b1 || eo_rd3 !== 32'h0 || bcs3 !== 3'b0) begin
      failures++;
      $display("FAIL xs_swap got=%0b/%0h/%0h exp=1/0/0", sack3, eo_rd3, bcs3);
    end
    sreq3 = 1'b0;
    bload3 = 1'b0;
    step();
    clr3();
    checks++;
    if (base3 !== 2'd1 || cnt3 !== 16'd4) begin
      failures++;
      $display("FAIL xs_load_ignored got=%0d/%0d exp=1/4", base3, cnt3);
    end
  endtask

  task automatic test_base_load();
    bload3 = 1'b1; bval3 = 2'd2;
    step();
    bload3 = 1'b0;
    checks++;
    if (base3 !== 2'd2) begin
      failures++;
      $display("FAIL ld_base got=%0d exp=2", base3);
    end
    ei_cs3 = 1'b1; ei_oe3 = 1'b1;
    #1;
    checks++;
    if (bcs3 !== 3'b100) begin
      failures++;
      $display("FAIL ld_in_map got=%0h exp=4", bcs3);
    end
    clr3();
    eo_cs3 = 1'b1; eo_oe3 = 1'b1;
    #1;
    checks++;
    if (bcs3 !== 3'b001) begin
      failures++;
      $display("FAIL ld_out_map got=%0h exp=1", bcs3);
    end
    clr3();
    bload3 = 1'b1; bval3 = 2'd3;
    step();
    bload3 = 1'b0;
    checks++;
    if (base3 !== 2'd0) begin
      failures++;
      $display("FAIL ld_mod got=%0d exp=0", base3);
    end
  endtask

  task automatic test_load_and_swap();
    bload3 = 1'b1; bval3 = 2'd2;
    sreq3 = 1'b1;
    step();
    bload3 = 1'b0;
    checks++;
    if (base3 !== 2'd2 || stall3 !== 1'b0) begin
      failures++;
      $display("FAIL ls_load got=%0d/%0b exp=2/0", base3, stall3);
    end
    step();
    checks++;
    if (stall3 !== 1'b1 || sack3 !== 1'b0) begin
      failures++;
      $display("FAIL ls_drain got=%0b/%0b exp=1/0", stall3, sack3);
    end
    step();
    checks++;
    if (sack3 !== 1'b1) begin
      failures++;
      $display("FAIL ls_ack got=%0b exp=1", sack3);
    end
    sreq3 = 1'b0;
    step();
    checks++;
    if (base3 !== 2'd0 || cnt3 !== 16'd5 || stall3 !== 1'b0) begin
      failures++;
      $display("FAIL ls_done got=%0d/%0d/%0b exp=0/5/0", base3, cnt3, stall3);
    end
  endtask

  task automatic test_num_buf2();
    brd2 = {32'h22222222, 32'h11111111};
    d_cs2 = 1'b1; d_oe2 = 1'b1; d_wr2 = 4'hF;
    d_wd2 = 32'hCAFEF00D; d_addr2 = 16'h0055;
    #1;
    checks++;
    if (bcs2 !== 2'b0 || bwr2 !== 8'h0 || bwd2 !== 64'h0 || baddr2 !== 32'h0) begin
      failures++;
      $display("FAIL n2_dma_blocked got=%0h/%0h/%0h exp=0/0/0", bcs2, bwr2, bwd2);
    end
    step();
    checks++;
    if (d_rd2 !== 32'h0) begin
      failures++;
      $display("FAIL n2_dma_rdata got=%0h exp=0", d_rd2);
    end
    clr2();
    ei_cs2 = 1'b1; ei_oe2 = 1'b1;
    #1;
    checks++;
    if (bcs2 !== 2'b01) begin
      failures++;
      $display("FAIL n2_in_map got=%0h exp=1", bcs2);
    end
    step();
    clr2();
    checks++;
    if (ei_rd2 !== 32'h11111111) begin
      failures++;
      $display("FAIL n2_in_rdata got=%0h exp=11111111", ei_rd2);
    end
    sreq2 = 1'b1;
    step();
    step();
    sreq2 = 1'b0;
    step();
    checks++;
    if (base2 !== 1'b1 || cnt2 !== 16'd1) begin
      failures++;
      $display("FAIL n2_swap got=%0d/%0d exp=1/1", base2, cnt2);
    end
    ei_cs2 = 1'b1; eo_cs2 = 1'b1; eo_wr2 = 4'h3;
    d_cs2 = 1'b1; d_wr2 = 4'hC;
    #1;
    checks++;
    if (bcs2 !== 2'b11 || bwr2 !== 8'h03) begin
      failures++;
      $display("FAIL n2_toggled got=%0h/%0h exp=3/03", bcs2, bwr2);
    end
    clr2();
    step();
  endtask

  task automatic test_num_buf4();
    ei_cs4 = 1'b1; ei_oe4 = 1'b1; ei_addr4 = 16'h0001;
    eo_cs4 = 1'b1; eo_oe4 = 1'b1; eo_addr4 = 16'h0002;
    d_cs4 = 1'b1; d_oe4 = 1'b1; d_addr4 = 16'h0003;
    #1;
    checks++;
    if (bcs4 !== 4'b0111 || boe4 !== 4'b0111 || baddr4[63:48] !== 16'h0) begin
      failures++;
      $display("FAIL n4_idle3 got=%0h/%0h/%0h exp=7/7/0", bcs4, boe4, baddr4[63:48]);
    end
    clr4();
    bload4 = 1'b1; bval4 = 2'd3;
    step();
    bload4 = 1'b0;
    ei_cs4 = 1'b1; eo_cs4 = 1'b1; d_cs4 = 1'b1;
    #1;
    checks++;
    if (base4 !== 2'd3 || bcs4 !== 4'b1011) begin
      failures++;
      $display("FAIL n4_wrap_map got=%0d/%0h exp=3/b", base4, bcs4);
    end
    clr4();
    sreq4 = 1'b1;
    step();
    checks++;
    if (stall4 !== 1'b1) begin
      failures++;
      $display("FAIL n4_drain got=%0b exp=1", stall4);
    end
    rst4 = 1'b1;
    #1;
    checks++;
    if (stall4 !== 1'b0 || sack4 !== 1'b0 || base4 !== 2'd0 || cnt4 !== 16'd0) begin
      failures++;
      $display("FAIL n4_abort got=%0b/%0b/%0d/%0d exp=0/0/0/0",
               stall4, sack4, base4, cnt4);
    end
    step();
    checks++;
    if (sack4 !== 1'b0) begin
      failures++;
      $display("FAIL n4_no_ack got=%0b exp=0", sack4);
    end
    rst4 = 1'b0;
    sreq4 = 1'b0;
    step();
    step();
    checks++;
    if (base4 !== 2'd0 || cnt4 !== 16'd0 || sack4 !== 1'b0) begin
      failures++;
      $display("FAIL n4_after got=%0d/%0d/%0b exp=0/0/0", base4, cnt4, sack4);
    end
  endtask

  initial begin
    rst3 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
    clr3(); clr2(); clr4();
    sreq3 = 1'b0; bload3 = 1'b0; bval3 = '0; brd3 = '0;
    sreq2 = 1'b0; bload2 = 1'b0; bval2 = '0; brd2 = '0;
    sreq4 = 1'b0; bload4 = 1'b0; bval4 = '0;
    brd4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    test_reset();
    test_mapping();
    test_write_path();
    test_three_swaps();
    test_read_across_swap();
    test_base_load();
    test_load_and_swap();
    test_num_buf2();
    test_num_buf4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/epu_buff_rotator.md
# epu_buff_rotator

Parametrised buffer-role rotator between the EPU and its bank of single-port SRAM feature-map buffers. It generalises fixed two-buffer in/out swapping to `NUM_BUF` buffers with three client roles: EPU input, EPU output and DMA. A request/acknowledge handshake advances the roles at layer boundaries, draining in-flight SRAM reads before the mapping changes. Read data follows a registered select, so each read returns from the buffer that was accessed even across a swap.

## Interface
- `NUM_BUF`, 3: number of buffers, 2..8. With 2 buffers the DMA role is absent.
- `ADDR_W`, 16: buffer address width.
- `DATA_W`, 32: buffer data width.
- `WEB_W`, 4: write-request (byte-enable) width.
- `clk` in 1: the block's only clock.
- `rst` in 1: asynchronous, active-high reset.
- `{epu_in,epu_out,dma}_cs_i / _oe_i` in 1 each: client chip select and output enable.
- `{epu_in,epu_out,dma}_addr_i` in ADDR_W: client address.
- `{epu_in,epu_out,dma}_W_req_i` in WEB_W: client write request.
- `{epu_in,epu_out,dma}_W_data_i` in DATA_W: client write data.
- `{epu_in,epu_out,dma}_R_data_o` out DATA_W: client read data.
- `buf_cs_o / buf_oe_o` out NUM_BUF: per-buffer chip select and output enable.
- `buf_addr_o` out NUM_BUF×ADDR_W: per-buffer address.
- `buf_W_req_o` out NUM_BUF×WEB_W: per-buffer write request.
- `buf_W_data_o` out NUM_BUF×DATA_W: per-buffer write data.
- `buf_R_data_i` in NUM_BUF×DATA_W: per-buffer read data, valid one cycle after `cs&oe`.
- `swap_req_i` in 1: level request to advance the roles.
- `swap_ack_o` out 1: one-cycle pulse when the new mapping is committed.
- `stall_o` out 1: clients must hold; their accesses are gated off.
- `base_load_i` in 1: force the base pointer.
- `base_val_i` in $clog2(NUM_BUF): value for the forced base pointer.
- `base_o` out $clog2(NUM_BUF): current base pointer.
- `swap_cnt_o` out 16: count of completed swaps, wraps at 2^16.

## Operation
- Role mapping from base pointer `b`:
  - EPU input → buffer `b`.
  - EPU output → buffer `(b+1) mod NUM_BUF`.
  - DMA → buffer `(b+2) mod NUM_BUF`, only when `NUM_BUF≥3`.
  - All other buffers are idle: every field driven 0.
- A swap sets `b ← (b+1) mod NUM_BUF`, so the previous output buffer becomes the next input buffer (layer chaining).
- Client-to-buffer paths are combinational from the current mapping. While `stall_o=1`, every `buf_cs_o`, `buf_oe_o` and `buf_W_req_o` is 0.
- Read return path: per client, register `rd_vld_q = cs&oe&!stall` and `rd_sel_q = mapped buffer`.
  - `R_data_o = buf_R_data_i[rd_sel_q]` when `rd_vld_q`, else 0.
  - `rd_sel_q` uses the mapping of the issue cycle, never the current mapping.
- FSM states: RUN, DRAIN, SWAP.
  - RUN → DRAIN on `swap_req_i=1`, unless `base_load_i=1` in the same cycle. In that case the load is taken, the FSM stays in RUN and the request is re-sampled next cycle.
  - DRAIN → SWAP unconditionally after 1 cycle; `stall_o=1`.
  - SWAP → RUN. In SWAP: `stall_o=1`, `swap_ack_o=1`, `b` and `swap_cnt_o` update at the end of the cycle.
- `base_load_i` is honoured only in RUN; it is ignored in DRAIN and SWAP. Values ≥ `NUM_BUF` are reduced mod `NUM_BUF`.
- With `NUM_BUF=2`: DMA inputs are ignored, `dma_R_data_o=0`, and the mapping toggles between 0/1 and 1/0.

## Timing
- Reset (async, active-high) gives:
  - state RUN, `b=0`, `swap_cnt_o=0`;
  - all `rd_vld_q=0`, so every `R_data_o=0`;
  - `swap_ack_o=0`, `stall_o=0`;
  - every `buf_cs_o=0` while `rst=1`.
- Request path: `swap_req_i` high in cycle t (RUN).
  - t+1 DRAIN, t+2 SWAP with the ack.
  - t+3 is RUN with the new mapping and `stall_o=0`.
  - Total: 2 stalled cycles.
- Accesses issued in cycle t complete normally; their read data is returned in t+1 from the old buffer.
- The requester must drop `swap_req_i` in the cycle after `swap_ack_o`. If it is still high in t+3, that is a new request.
- Reset mid-swap aborts the swap: `b` is unchanged (0 after reset), `swap_cnt_o` is unchanged (0 after reset), and no ack is issued.
- `b` wraps from `NUM_BUF-1` to 0. `swap_cnt_o` wraps from 0xFFFF to 0.
- Write path: `buf_W_req_o` follows the client combinationally in the same cycle, with no added latency.

## Test plan
- Reset check, `NUM_BUF=3`: EPU-in read of addr 0x10 → `buf_cs_o=3'b001`, `buf_addr_o[0]=0x10`. Next cycle `epu_in_R_data_o = buf_R_data_i[0]`. `epu_out` maps to buffer 1, `dma` to buffer 2.
- Three swaps in sequence:
  - each request gives the ack exactly 2 cycles after it and 2 cycles of `stall_o`;
  - `base_o` steps 1, 2, 0;
  - `swap_cnt_o=3`;
  - after the first swap, an EPU-in read hits buffer 1.
- Read issued in the same cycle as `swap_req_i` (EPU-out reading buffer 1, with 0xDEADBEEF on `buf_R_data_i[1]`) → `epu_out_R_data_o=0xDEADBEEF` in the next cycle, the DRAIN cycle.
- Accesses during DRAIN/SWAP → all `buf_cs_o=0`, `buf_W_req_o=0`. `base_load_i=1` with `base_val_i=2` during DRAIN is ignored. The same load in RUN gives `base_o=2`, EPU-in → buffer 2, EPU-out → buffer 0.
- `base_load_i` and `swap_req_i` together in RUN → the load is taken, the swap follows, and the final `base_o` is `(val+1) mod NUM_BUF`.
- `NUM_BUF=2`, and `NUM_BUF=4` with `rst` asserted in DRAIN:
  - `NUM_BUF=2`: DMA writes never reach a buffer.
  - `NUM_BUF=4`: buffer 3 is idle at `b=0`; the reset yields `base_o=0`, no ack and `swap_cnt_o=0`.
